// File: rtl/td4_pkg.sv
// td4_pkg: shared opcode, mux-select and FSM state encodings for the TD4 sequencer
package td4_pkg;
  localparam logic [3:0] OP_ADD_A  = 4'h0;
  localparam logic [3:0] OP_MOV_AB = 4'h1;
  localparam logic [3:0] OP_IN_A   = 4'h2;
  localparam logic [3:0] OP_MOV_A  = 4'h3;
  localparam logic [3:0] OP_MOV_BA = 4'h4;
  localparam logic [3:0] OP_ADD_B  = 4'h5;
  localparam logic [3:0] OP_IN_B   = 4'h6;
  localparam logic [3:0] OP_MOV_B  = 4'h7;
  localparam logic [3:0] OP_OUT_B  = 4'h9;
  localparam logic [3:0] OP_OUT    = 4'hB;
  localparam logic [3:0] OP_JNC    = 4'hE;
  localparam logic [3:0] OP_JMP    = 4'hF;
  localparam logic [1:0] SEL_A    = 2'b00;
  localparam logic [1:0] SEL_B    = 2'b01;
  localparam logic [1:0] SEL_IN   = 2'b10;
  localparam logic [1:0] SEL_ZERO = 2'b11;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_HALT = 2'd2} state_t;
endpackage

// File: rtl/td4_prescaler.sv
// td4_prescaler: counts 0..PRESCALE-1 while enabled, tick on the terminal count
module td4_prescaler #(
  parameter logic [15:0] PRESCALE = 16'd10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);
  logic [15:0] cnt;
  assign tick = !clr && cnt == PRESCALE - 16'd1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (clr || tick) ? '0 : cnt + 16'd1;
endmodule

// File: rtl/td4_sequencer.sv
// td4_sequencer: TD4 program counter, carry flag, instruction decode and run/step/halt pacing
module td4_sequencer
  import td4_pkg::*;
#(
  parameter logic [15:0] PRESCALE = 16'd10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       step,
  input  logic [7:0] instr,
  input  logic       carry_in,
  output logic [3:0] address,
  output logic [1:0] sel,
  output logic [3:0] imm,
  output logic       load_a,
  output logic       load_b,
  output logic       load_out,
  output logic       exec,
  output logic       cflag,
  output logic       halted
);
  state_t state, state_nx;
  logic [3:0] op;
  logic [2:0] ld;
  logic tick, taken, halt_c;
  assign op = instr[7:4];
  assign imm = instr[3:0];
  td4_prescaler #(.PRESCALE(PRESCALE)) u_pre (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state != ST_RUN),
    .tick (tick)
  );
  // run beats step when both are asserted in IDLE
  assign exec = (state == ST_IDLE && step && !run) || (state == ST_RUN && tick);
  assign taken = op == OP_JMP || (op == OP_JNC && !cflag);
  assign halt_c = exec && taken && imm == address;
  assign halted = state == ST_HALT;
  assign {load_a, load_b, load_out} = exec ? ld : 3'b000;
  always_comb begin
    sel = SEL_ZERO;
    ld = 3'b000;
    case (op)
      OP_ADD_A:  begin sel = SEL_A;    ld = 3'b100; end
      OP_MOV_AB: begin sel = SEL_B;    ld = 3'b100; end
      OP_IN_A:   begin sel = SEL_IN;   ld = 3'b100; end
      OP_MOV_A:  begin sel = SEL_ZERO; ld = 3'b100; end
      OP_MOV_BA: begin sel = SEL_A;    ld = 3'b010; end
      OP_ADD_B:  begin sel = SEL_B;    ld = 3'b010; end
      OP_IN_B:   begin sel = SEL_IN;   ld = 3'b010; end
      OP_MOV_B:  begin sel = SEL_ZERO; ld = 3'b010; end
      OP_OUT_B:  begin sel = SEL_B;    ld = 3'b001; end
      OP_OUT:    begin sel = SEL_ZERO; ld = 3'b001; end
      default:   begin sel = SEL_ZERO; ld = 3'b000; end
    endcase
  end
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: state_nx = halt_c ? ST_HALT : run ? ST_RUN : ST_IDLE;
      ST_RUN:  state_nx = halt_c ? ST_HALT : run ? ST_RUN : ST_IDLE;
      default: state_nx = ST_HALT;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      address <= '0;
      cflag <= 1'b0;
    end else begin
      state <= state_nx;
      if (exec) begin
        cflag <= carry_in;
        address <= taken ? imm : address + 4'd1;
      end
    end
endmodule

// File: tb/tb_td4_sequencer.sv
// tb_td4_sequencer: table-driven STEP vectors with an address/flag scoreboard plus corner sequences
module tb_td4_sequencer;
  logic clk = 0, rst_n = 0, run = 0, step = 0, carry_in = 0;
  logic [7:0] instr = 8'h80;
  logic [3:0] address, imm;
  logic [1:0] sel;
  logic load_a, load_b, load_out, exec, cflag, halted;
  int vectors = 0, miscompares = 0;
  typedef struct {logic [7:0] instr; logic carry; logic [1:0] sel; logic [2:0] ld;} vec_t;
  typedef struct {logic [3:0] addr; logic cf;} exp_t;
  vec_t tbl[16];
  exp_t sb[$];
  exp_t e;
  logic [3:0] m_addr;
  logic m_cf, m_taken;
  always #5 clk = ~clk;
  td4_sequencer #(.PRESCALE(16'd4)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step), .instr(instr), .carry_in(carry_in),
    .address(address), .sel(sel), .imm(imm), .load_a(load_a), .load_b(load_b),
    .load_out(load_out), .exec(exec), .cflag(cflag), .halted(halted)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    run = 0; step = 0; carry_in = 0; instr = 8'h80;
    rst_n = 0;
    #2 rst_n = 1;
  endtask
  task automatic do_step(input logic [7:0] i, input logic c);
    @(negedge clk);
    instr = i; carry_in = c; step = 1;
    @(posedge clk);
    #1 step = 0;
  endtask
  initial begin
    tbl[0]  = '{8'h00, 1'b0, 2'b00, 3'b100};
    tbl[1]  = '{8'h15, 1'b1, 2'b01, 3'b100};
    tbl[2]  = '{8'h2A, 1'b0, 2'b10, 3'b100};
    tbl[3]  = '{8'h33, 1'b0, 2'b11, 3'b100};
    tbl[4]  = '{8'h4F, 1'b1, 2'b00, 3'b010};
    tbl[5]  = '{8'h51, 1'b0, 2'b01, 3'b010};
    tbl[6]  = '{8'h62, 1'b0, 2'b10, 3'b010};
    tbl[7]  = '{8'h7C, 1'b0, 2'b11, 3'b010};
    tbl[8]  = '{8'h93, 1'b0, 2'b01, 3'b001};
    tbl[9]  = '{8'hB7, 1'b0, 2'b11, 3'b001};
    tbl[10] = '{8'h85, 1'b1, 2'b11, 3'b000};
    tbl[11] = '{8'hE2, 1'b0, 2'b11, 3'b000};
    tbl[12] = '{8'hE1, 1'b1, 2'b11, 3'b000};
    tbl[13] = '{8'hF9, 1'b0, 2'b11, 3'b000};
    tbl[14] = '{8'hA4, 1'b0, 2'b11, 3'b000};
    tbl[15] = '{8'hC0, 1'b0, 2'b11, 3'b000};
    #2 rst_n = 0;
    #4 chk("reset_state", {address, cflag, exec, halted, load_a, load_b, load_out}, 10'h0);
    rst_n = 1;
    // table: single steps from IDLE, outputs same cycle, PC/flag popped after the edge
    m_addr = 0; m_cf = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      instr = tbl[i].instr; carry_in = tbl[i].carry; step = 1;
      #1 chk($sformatf("decode[%0d]", i), {sel, imm, load_a, load_b, load_out, exec},
             {tbl[i].sel, tbl[i].instr[3:0], tbl[i].ld, 1'b1});
      m_taken = tbl[i].instr[7:4] == 4'hF || (tbl[i].instr[7:4] == 4'hE && !m_cf);
      m_addr = m_taken ? tbl[i].instr[3:0] : m_addr + 4'd1;
      m_cf = tbl[i].carry;
      sb.push_back('{m_addr, m_cf});
      @(posedge clk);
      #1 step = 0;
      e = sb.pop_front();
      chk($sformatf("pc_flag[%0d]", i), {address, cflag}, {e.addr, e.cf});
    end
    @(negedge clk);
    chk("idle_no_exec", {exec, load_a, load_b, load_out}, 4'h0);
    // JNC taken with clear flag, then not taken with set flag
    do_reset();
    do_step(8'h00, 1'b0);
    do_step(8'h00, 1'b0);
    chk("jnc_setup", {address, cflag}, {4'h2, 1'b0});
    do_step(8'hE1, 1'b0);
    chk("jnc_taken", address, 4'h1);
    do_step(8'h00, 1'b1);
    chk("jnc_setup2", {address, cflag}, {4'h2, 1'b1});
    do_step(8'hE1, 1'b1);
    chk("jnc_not_taken", {address, cflag}, {4'h3, 1'b1});
    // RUN pacing with PRESCALE=4
    do_reset();
    @(negedge clk);
    run = 1;
    @(posedge clk);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk($sformatf("run_exec[%0d]", k), exec, (k % 4) == 0);
    end
    @(negedge clk);
    chk("run_pc", address, 4'h3);
    run = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("stopped_exec", exec, 1'b0);
    end
    chk("stopped_pc", address, 4'h3);
    // asynchronous reset in the middle of a RUN count
    do_reset();
    @(negedge clk);
    run = 1; carry_in = 1;
    repeat (10) @(negedge clk);
    chk("pre_reset", {address, cflag}, {4'h2, 1'b1});
    #2 rst_n = 0;
    #1 chk("mid_run_reset", {address, cflag, exec, halted}, 7'h0);
    run = 0;
    @(negedge clk);
    rst_n = 1;
    // jump-to-self halts; step and run are then ignored
    do_reset();
    do_step(8'hFF, 1'b0);
    chk("jmp_to_f", {address, halted}, {4'hF, 1'b0});
    do_step(8'hFF, 1'b1);
    chk("halt_entry", {address, cflag, halted}, {4'hF, 1'b1, 1'b1});
    @(negedge clk);
    run = 1; step = 1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("halt_hold", {exec, address, halted}, {1'b0, 4'hF, 1'b1});
    end
    run = 0; step = 0;
    // PC wrap F -> 0
    do_reset();
    do_step(8'hFF, 1'b0);
    @(negedge clk);
    instr = 8'h01; carry_in = 0; step = 1;
    #1 chk("wrap_decode", {load_a, sel, exec}, {1'b1, 2'b00, 1'b1});
    @(posedge clk);
    #1 step = 0;
    chk("wrap_pc", {address, halted}, {4'h0, 1'b0});
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
